alu_input_sequencer: RTL and testbench
======================================

Name: alu_input_sequencer

Overview:
- Upstream feeder for the N-bit ALU on the lab board.
- Loads operand A, operand B and the 4-bit opcode from the switch bank in three button-stepped phases, then holds them stable on the ALU inputs.
- Captures the ALU result and its four flags one cycle later and holds them for display.
- Contains button synchronisation, debouncing and edge detection, so raw pushbuttons connect directly.

Parameters:
- N, 4, operand width; must be >= 4 because opcode is taken from sw[3:0].
- DB_CYCLES, 16, consecutive stable synchronised cycles required before a button level is accepted. Use 16 for simulation; use board value for synthesis.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw  in  N  raw switch bank (operand or opcode source)
- btn_step  in  1  raw async pushbuttons, active-high
- btn_clear  in  1  raw async pushbuttons, active-high
- alu_a  out  N  registered operand A to ALU
- alu_b  out  N  registered operand B to ALU
- alu_s  out  4  registered opcode to ALU
- alu_result  in  N  ALU result
- alu_flags  in  4  {neg, zr, cry, of} from ALU
- res_q  out  N  captured result
- flags_q  out  4  captured {neg, zr, cry, of}
- res_valid  out  1  high while in SHOW
- err_op  out  1  last opcode attempt was invalid
- state_o  out  3  FSM state encoding, for LEDs

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, state A (state_o=0), debounce counters 0. Reset mid-operation aborts immediately, with no capture.
- Button path, per button:
  - SYNC_STAGES-FF synchroniser, then debounce counter.
  - Counter resets to 0 on any change of the synchronised level.
  - Accepted level updates after DB_CYCLES stable cycles.
  - Rising edge of accepted level gives a one-cycle pulse.
  - Clean press: pulse exactly SYNC_STAGES+DB_CYCLES+1 cycles after the first sampled high. One pulse per press; holding the button never repeats.
- FSM states and encodings: A=0, B=1, OP=2, EXEC=3, SHOW=4.
  - A: step -> alu_a<=sw, go B.
  - B: step -> alu_b<=sw, go OP.
  - OP, step with sw[3:0] <= 9 -> alu_s<=sw[3:0], err_op<=0, go EXEC.
  - OP, step with sw[3:0] >= 10 -> stay in OP, alu_s unchanged, err_op<=1.
  - EXEC: exactly one cycle. ALU is combinational and the operands have been stable for >=1 cycle. At the end of EXEC: res_q<=alu_result, flags_q<=alu_flags, go SHOW.
  - SHOW: res_valid=1. res_q/flags_q/alu_* held. Step -> go A, res_valid<=0. res_q/flags_q are retained until the next capture.
- Clear pulse, in any state: go A; alu_a, alu_b, alu_s, err_op, res_valid <= 0. res_q/flags_q are retained.
- Clear and step pulses in the same cycle: clear wins and the step is discarded.
- Steps arriving during EXEC are ignored; this cannot occur with DB_CYCLES >= 1.
- alu_a/alu_b/alu_s change only on the transitions listed above, never combinationally from sw.
- state_o is a registered copy of the state; values 5..7 are unreachable and recover to A.

Decomposition:
- Package alu_seq_pkg:
  - state enum (A, B, OP, EXEC, SHOW as 3-bit).
  - localparam OP_MAX = 9.
  - flag index constants: FLG_NEG=3, FLG_ZR=2, FLG_CRY=1, FLG_OF=0.
- Sub-module btn_conditioner: synchroniser + debounce + rising-edge pulse, parameterised by SYNC_STAGES and DB_CYCLES. Instantiate it twice, once for step and once for clear.
- Top module: FSM and capture registers.

Test Plan:
- Reset: rst=1 for 2 cycles with buttons and sw toggling -> all outputs 0, state_o=0; after release, no spurious pulse.
- Full add, with the ALU model computing a+b with 4-bit flags: sw=3 step, sw=5 step, sw=0 step -> alu_a=3, alu_b=5, alu_s=0; one cycle after EXEC, res_q=8, flags_q=4'b1001 (neg=1, of=1), res_valid=1. Next step -> state_o=0, res_valid=0.
- Bounce: btn_step toggles every 3 cycles for 30 cycles, then holds high for 25 cycles -> no pulse during bouncing; exactly one pulse 19 cycles after the stable high begins; state A->B.
- Invalid opcode in OP: sw=4'hC step -> state_o stays 2, err_op=1, alu_s unchanged. Then sw=4'h2 step -> alu_s=2, err_op=0, state EXEC.
- Clear and step coincident in B, with alu_a=7 -> state_o=0, alu_a=alu_b=alu_s=0, and the step is not consumed.
- Reset asserted during EXEC -> next cycle res_valid=0, state_o=0, res_q=0 (no capture).

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU input sequencer: FSM states,
// opcode limit and the ALU flag layout.
package alu_seq_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned FLG_W = 4;

  localparam logic [OP_W-1:0] OP_MAX = 4'd9;

  localparam int unsigned FLG_NEG = 3;
  localparam int unsigned FLG_ZR  = 2;
  localparam int unsigned FLG_CRY = 1;
  localparam int unsigned FLG_OF  = 0;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_OP   = 3'd2,
    ST_EXEC = 3'd3,
    ST_SHOW = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic neg;
    logic zr;
    logic cry;
    logic of;
  } alu_flags_t;

  // Map the raw ALU flag bus onto named fields.
  function automatic alu_flags_t unpack_flags(input logic [FLG_W-1:0] f);
    alu_flags_t r;
    r.neg = f[FLG_NEG];
    r.zr  = f[FLG_ZR];
    r.cry = f[FLG_CRY];
    r.of  = f[FLG_OF];
    return r;
  endfunction

  function automatic logic op_valid(input logic [OP_W-1:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/alu_input_sequencer_btn.sv
// Pushbutton conditioner: synchroniser, stable-level debounce and a
// single-cycle pulse on each accepted rising edge.
module btn_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   sync_prev;
  logic [CNT_W-1:0]       cnt_q;
  logic                   accepted_q;
  logic                   accepted_d;
  logic                   stable;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign stable   = (sync_lvl == sync_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      sync_prev  <= 1'b0;
      cnt_q      <= '0;
      accepted_q <= 1'b0;
      accepted_d <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      sync_q    <= (sync_q << 1) | SYNC_STAGES'(btn);
      sync_prev <= sync_lvl;
      // Any change of the synchronised level restarts the stability window.
      if (!stable) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(DB_CYCLES)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (stable && (cnt_q == CNT_W'(DB_CYCLES - 1))) begin
        accepted_q <= sync_lvl;
      end
      accepted_d <= accepted_q;
      pulse      <= accepted_q & ~accepted_d;
    end
  end

endmodule

// File: rtl/alu_input_sequencer.sv
// Button-stepped operand/opcode loader for the lab-board ALU; captures the
// ALU result and flags one cycle after the operands are committed.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn_step,
  input  logic         btn_clear,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_s,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [N-1:0] res_q,
  output logic [3:0]   flags_q,
  output logic         res_valid,
  output logic         err_op,
  output logic [2:0]   state_o
);

  logic step_p;
  logic clear_p;

  btn_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_step (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_step),
    .pulse(step_p)
  );

  btn_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_clear (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_clear),
    .pulse(clear_p)
  );

  seq_state_t   state_q;
  seq_state_t   state_n;
  logic [N-1:0] a_n;
  logic [N-1:0] b_n;
  logic [3:0]   s_n;
  logic         err_n;
  logic [N-1:0] res_n;
  alu_flags_t   flags_r;
  alu_flags_t   flags_n;

  assign state_o = state_q;
  assign flags_q = flags_r;

  // Next-state and next-register values; clear overrides any step.
  always_comb begin
    state_n = state_q;
    a_n     = alu_a;
    b_n     = alu_b;
    s_n     = alu_s;
    err_n   = err_op;
    res_n   = res_q;
    flags_n = flags_r;
    if (clear_p) begin
      state_n = ST_A;
      a_n     = '0;
      b_n     = '0;
      s_n     = '0;
      err_n   = 1'b0;
    end else begin
      case (state_q)
        ST_A: begin
          if (step_p) begin
            a_n     = sw;
            state_n = ST_B;
          end
        end
        ST_B: begin
          if (step_p) begin
            b_n     = sw;
            state_n = ST_OP;
          end
        end
        ST_OP: begin
          if (step_p) begin
            if (op_valid(sw[3:0])) begin
              s_n     = sw[3:0];
              err_n   = 1'b0;
              state_n = ST_EXEC;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        ST_EXEC: begin
          res_n   = alu_result;
          flags_n = unpack_flags(alu_flags);
          state_n = ST_SHOW;
        end
        ST_SHOW: begin
          if (step_p) begin
            state_n = ST_A;
          end
        end
        default: state_n = ST_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      err_op    <= 1'b0;
      res_q     <= '0;
      flags_r   <= '0;
      res_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      alu_a     <= a_n;
      alu_b     <= b_n;
      alu_s     <= s_n;
      err_op    <= err_n;
      res_q     <= res_n;
      flags_r   <= flags_n;
      res_valid <= (state_n == ST_SHOW);
    end
  end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Randomised and directed bench for alu_input_sequencer against a
// transaction-level model of the load/execute/show sequence.
module tb_alu_input_sequencer;

  localparam int unsigned N   = 4;
  localparam int unsigned DB  = 16;
  localparam int unsigned SS  = 2;
  localparam int          LAT = int'(SS + DB + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw = '0;
  logic         btn_step = 1'b0;
  logic         btn_clear = 1'b0;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_s;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic [N-1:0] res_q;
  logic [3:0]   flags_q;
  logic         res_valid;
  logic         err_op;
  logic [2:0]   state_o;

  alu_input_sequencer #(.N(N), .DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_step  (btn_step),
    .btn_clear (btn_clear),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_result(alu_result),
    .alu_flags (alu_flags),
    .res_q     (res_q),
    .flags_q   (flags_q),
    .res_valid (res_valid),
    .err_op    (err_op),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Combinational ALU on the board: returns {result, neg, zr, cry, of}.
  function automatic logic [N+3:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [3:0] s);
    logic [N:0]   wide;
    logic [N-1:0] r;
    logic         of;
    wide = '0;
    of   = 1'b0;
    case (s)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        of   = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
      end
      4'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        of   = (a[N-1] != b[N-1]) && (wide[N-1] != a[N-1]);
      end
      4'd2: wide = {1'b0, a & b};
      4'd3: wide = {1'b0, a | b};
      4'd4: wide = {1'b0, a ^ b};
      4'd5: wide = {1'b0, ~a};
      4'd6: wide = {a, 1'b0};
      4'd7: wide = {1'b0, a >> 1};
      4'd8: wide = {1'b0, a} + (N+1)'(1);
      4'd9: wide = {1'b0, a} - (N+1)'(1);
      default: wide = '0;
    endcase
    r = wide[N-1:0];
    return {r, r[N-1], (r == '0), wide[N], of};
  endfunction

  always_comb {alu_result, alu_flags} = alu_fn(alu_a, alu_b, alu_s);

  // Reference model: how many operands are loaded, and whether a result is on show.
  int           m_loaded;
  logic         m_show;
  logic [N-1:0] m_a, m_b, m_res;
  logic [3:0]   m_s, m_flags;
  logic         m_err;

  int total = 0;
  int bad   = 0;

  function automatic int m_state();
    return m_show ? 4 : m_loaded;
  endfunction

  task automatic model_reset();
    m_loaded = 0; m_show = 1'b0; m_a = '0; m_b = '0; m_s = '0;
    m_err = 1'b0; m_res = '0; m_flags = '0;
  endtask

  task automatic model_clear();
    m_loaded = 0; m_show = 1'b0; m_a = '0; m_b = '0; m_s = '0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] v);
    if (m_show) begin
      m_show   = 1'b0;
      m_loaded = 0;
    end else if (m_loaded == 0) begin
      m_a = v; m_loaded = 1;
    end else if (m_loaded == 1) begin
      m_b = v; m_loaded = 2;
    end else if (v[3:0] <= 4'd9) begin
      m_s = v[3:0]; m_err = 1'b0; m_show = 1'b1;
      {m_res, m_flags} = alu_fn(m_a, m_b, v[3:0]);
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".state"},  32'(state_o),   32'(m_state()));
    check_val({tag, ".a"},      32'(alu_a),     32'(m_a));
    check_val({tag, ".b"},      32'(alu_b),     32'(m_b));
    check_val({tag, ".s"},      32'(alu_s),     32'(m_s));
    check_val({tag, ".err"},    32'(err_op),    32'(m_err));
    check_val({tag, ".valid"},  32'(res_valid), 32'(m_show));
    check_val({tag, ".res"},    32'(res_q),     32'(m_res));
    check_val({tag, ".flags"},  32'(flags_q),   32'(m_flags));
  endtask

  // Clean press (optionally both buttons); rst_k > 0 injects reset after sample rst_k.
  task automatic press(input string tag, input logic do_step, input logic do_clr,
                       input logic [N-1:0] v, input int rst_k);
    int hist [LAT+5];
    int pre, post, first, moved;
    @(negedge clk);
    sw = v; btn_step = do_step; btn_clear = do_clr;
    pre   = m_state();
    moved = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      hist[k] = int'(state_o);
      if (k <= LAT + 1 && hist[k] != pre) moved++;
      if (rst_k > 0 && k == rst_k + 1) begin
        check_val({tag, ".rst_state"}, 32'(state_o),   32'd0);
        check_val({tag, ".rst_valid"}, 32'(res_valid), 32'd0);
        check_val({tag, ".rst_res"},   32'(res_q),     32'd0);
      end
      if (rst_k > 0 && k == rst_k) begin
        rst = 1'b1; btn_step = 1'b0; btn_clear = 1'b0;
      end else if (rst) begin
        rst = 1'b0;
      end
    end
    check_val({tag, ".early"}, 32'(moved), 32'd0);
    if (rst_k > 0) begin
      check_val({tag, ".exec"}, 32'(hist[rst_k]), 32'd3);
      model_reset();
    end else begin
      if (do_clr) model_clear();
      else if (do_step) model_step(v);
      post  = m_state();
      first = (pre == 2 && post == 4) ? 3 : post;
      check_val({tag, ".edge"}, 32'(hist[LAT+2]), 32'(first));
      if (first == 3) check_val({tag, ".show"}, 32'(hist[LAT+3]), 32'd4);
    end
    @(negedge clk);
    btn_step = 1'b0; btn_clear = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int bounced;
    int r;
    model_reset();
    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sw = N'(i + 5); btn_step = i[0]; btn_clear = ~i[0];
    end
    @(posedge clk); #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0; btn_step = 1'b0; btn_clear = 1'b0;
    repeat (LAT + 10) @(posedge clk);
    #1;
    check_all("post_reset");

    // Full add: 3 + 5 -> 8 with neg and overflow.
    press("add_a", 1'b1, 1'b0, N'(3), 0);
    press("add_b", 1'b1, 1'b0, N'(5), 0);
    press("add_op", 1'b1, 1'b0, N'(0), 0);
    check_val("add.res",   32'(res_q),     32'd8);
    check_val("add.flags", 32'(flags_q),   32'b1001);
    check_val("add.valid", 32'(res_valid), 32'd1);
    press("add_back", 1'b1, 1'b0, N'(1), 0);
    check_val("add.back", 32'(state_o), 32'd0);

    // Bounce for 30 cycles, then a stable press.
    bounced = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      btn_step = ((i / 3) % 2 == 0);
      if (state_o != 3'd0) bounced++;
    end
    check_val("bounce.quiet", 32'(bounced), 32'd0);
    press("bounce_press", 1'b1, 1'b0, N'(6), 0);

    // Invalid opcode then a valid one.
    press("inv_b", 1'b1, 1'b0, N'(4), 0);
    press("inv_op", 1'b1, 1'b0, N'(12), 0);
    check_val("inv.err",   32'(err_op),  32'd1);
    check_val("inv.state", 32'(state_o), 32'd2);
    press("inv_fix", 1'b1, 1'b0, N'(2), 0);
    check_val("fix.s",   32'(alu_s),  32'd2);
    check_val("fix.err", 32'(err_op), 32'd0);
    press("inv_back", 1'b1, 1'b0, N'(0), 0);

    // Clear coincident with step in B.
    press("cs_a", 1'b1, 1'b0, N'(7), 0);
    press("cs_both", 1'b1, 1'b1, N'(9), 0);
    check_val("cs.state", 32'(state_o), 32'd0);
    check_val("cs.a",     32'(alu_a),   32'd0);

    // Reset during EXEC aborts without capture.
    press("rx_a", 1'b1, 1'b0, N'(5), 0);
    press("rx_b", 1'b1, 1'b0, N'(6), 0);
    press("rx_op", 1'b1, 1'b0, N'(0), LAT + 2);

    // Random mix of steps, clears and coincident presses.
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      press("rnd_clr",  1'b0, 1'b1, N'($urandom_range(0, 15)), 0);
      else if (r == 1) press("rnd_both", 1'b1, 1'b1, N'($urandom_range(0, 15)), 0);
      else             press("rnd_step", 1'b1, 1'b0, N'($urandom_range(0, 15)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
